// File: rtl/dds_pkg.sv
// Shared definitions for the DDS output stage: sample width and DAC mode encoding.
package dds_pkg;

  localparam int DDS_SAMPLE_W = 8;

  typedef enum logic {
    DAC_MODE_PWM = 1'b0,
    DAC_MODE_SD  = 1'b1
  } dac_mode_e;

endpackage

// File: rtl/dds_sd_mod.sv
// First-order sigma-delta modulator: an accumulator whose carry out is the 1-bit drive.
module dds_sd_mod
  import dds_pkg::*;
#(
  parameter int DATA_W = DDS_SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample,
  output logic              bit_out
);

  logic [DATA_W:0] acc_q;
  logic [DATA_W:0] acc_d;
  logic [DATA_W:0] sum;

  // Add the new sample to the residue; clear wins over accumulate, otherwise hold.
  always_comb begin
    sum   = {1'b0, acc_q[DATA_W-1:0]} + {1'b0, sample};
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = sum;
    end
  end

  // The carry of this cycle's addition is the next output bit; the caller registers it.
  assign bit_out = sum[DATA_W];

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dds_pwm_dac.sv
// 1-bit DAC output stage: PWM with a boundary-latched duty, or sigma-delta, chosen per period.
module dds_pwm_dac
  import dds_pkg::*;
#(
  parameter int DATA_W = DDS_SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic [DATA_W-1:0] sample_in,
  output logic              dac_out,
  output logic              period_start,
  output logic [DATA_W-1:0] duty_q
);

  localparam logic [DATA_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;
  logic [DATA_W-1:0] duty_d;
  dac_mode_e         mode_q;
  dac_mode_e         mode_d;
  dac_mode_e         mode_req;
  logic              dac_out_q;
  logic              dac_out_d;
  logic              boundary;
  logic              sd_clear;
  logic              sd_enable;
  logic              sd_bit;

  // Boundary decode and control for the sigma-delta accumulator.
  always_comb begin
    mode_req  = dac_mode_e'(mode);
    boundary  = enable && (cnt_q == CNT_MAX);
    sd_clear  = !enable || (boundary && (mode_req != mode_q));
    sd_enable = enable && (mode_q == DAC_MODE_SD);
  end

  // Next-state: idle reloads reset values; otherwise count, latch duty/mode at the boundary, drive the pin.
  always_comb begin
    cnt_d     = cnt_q + CNT_ONE;
    duty_d    = duty_q;
    mode_d    = mode_q;
    dac_out_d = 1'b0;
    if (!enable) begin
      cnt_d     = CNT_MAX;
      duty_d    = '0;
      mode_d    = DAC_MODE_PWM;
      dac_out_d = 1'b0;
    end else begin
      if (boundary) begin
        duty_d = sample_in;
        mode_d = mode_req;
      end
      if (mode_q == DAC_MODE_SD) begin
        dac_out_d = sd_bit;
      end else begin
        dac_out_d = (cnt_q < duty_q);
      end
    end
  end

  // State registers; reset parks the counter at MAX so the first enabled edge starts a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= CNT_MAX;
      duty_q    <= '0;
      mode_q    <= DAC_MODE_PWM;
      dac_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      mode_q    <= mode_d;
      dac_out_q <= dac_out_d;
    end
  end

  dds_sd_mod #(
    .DATA_W(DATA_W)
  ) u_sd (
    .clk     (clk),
    .rst     (rst),
    .clear   (sd_clear),
    .enable  (sd_enable),
    .sample  (sample_in),
    .bit_out (sd_bit)
  );

  assign dac_out      = dac_out_q;
  assign period_start = enable && (cnt_q == '0);

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Scoreboard bench for dds_pwm_dac: per-period expectations are queued by the stimulus
// and checked by a monitor that measures each period delimited by period_start.
module tb_dds_pwm_dac;
  import dds_pkg::*;

  typedef struct {
    logic [7:0] duty;
    int         ones;
    int         runs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [7:0] sample_in;
  logic       dac_out;
  logic       period_start;
  logic [7:0] duty_q;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pos      = 0;

  // monitor state
  bit         mon_active = 1'b0;
  int         mon_len    = 0;
  int         mon_ones   = 0;
  int         mon_runs   = 0;
  logic       mon_prev   = 1'b0;
  logic [7:0] mon_duty   = 8'h00;

  always #5 clk = ~clk;

  dds_pwm_dac #(
    .DATA_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .sample_in    (sample_in),
    .dac_out      (dac_out),
    .period_start (period_start),
    .duty_q       (duty_q)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic md, input logic [7:0] smp);
    enable    = en;
    mode      = md;
    sample_in = smp;
  endtask

  task automatic advanceTo(input int target);
    repeat (target - pos) @(posedge clk);
    #1;
    pos = target;
  endtask

  task automatic pushExp(input logic [7:0] duty, input int ones, input int runs);
    exp_t e;
    e.duty = duty;
    e.ones = ones;
    e.runs = runs;
    sb_q.push_back(e);
  endtask

  // Monitor: each window covers the 256 samples after a period_start, ending on the next one.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !enable) begin
        mon_active = 1'b0;
      end else begin
        if (mon_active) begin
          mon_len++;
          if (dac_out) mon_ones++;
          if (dac_out && !mon_prev) mon_runs++;
          mon_prev = dac_out;
        end
        if (period_start) begin
          if (mon_active) begin
            if (sb_q.size() == 0) begin
              checkOutput("sb_unexpected_period", 32'd1, 32'd0);
            end else begin
              e = sb_q.pop_front();
              checkOutput("period_len", mon_len, 256);
              checkOutput("period_duty", {24'd0, mon_duty}, {24'd0, e.duty});
              checkOutput("period_ones", mon_ones, e.ones);
              checkOutput("period_runs", mon_runs, e.runs);
            end
          end
          mon_active = 1'b1;
          mon_len    = 0;
          mon_ones   = 0;
          mon_runs   = 0;
          mon_prev   = dac_out;
          mon_duty   = duty_q;
        end
      end
    end
  end

  // Stimulus: directed timeline in edges since the first enabled edge.
  initial begin : stimulus
    rst = 1'b1;
    applyStimulus(1'b0, DAC_MODE_PWM, 8'h40);
    #2;
    checkOutput("reset_dac_out", {31'd0, dac_out}, 0);
    checkOutput("reset_duty", {24'd0, duty_q}, 0);
    checkOutput("reset_period_start", {31'd0, period_start}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_period_start", {31'd0, period_start}, 0);

    // PWM at 0x40, then 0x00, 0xFF, and a mid-period change 0x40 -> 0xC0
    pushExp(8'h40, 64, 1);
    pushExp(8'h40, 64, 1);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'h40);
    @(posedge clk);
    #1;
    pos = 0;
    checkOutput("first_period_start", {31'd0, period_start}, 1);
    checkOutput("first_duty", {24'd0, duty_q}, 8'h40);
    checkOutput("first_dac_low", {31'd0, dac_out}, 0);
    advanceTo(1);
    checkOutput("pulse_starts", {31'd0, dac_out}, 1);
    checkOutput("ps_one_cycle", {31'd0, period_start}, 0);
    advanceTo(300);
    pushExp(8'h00, 0, 0);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'h00);
    advanceTo(600);
    pushExp(8'hFF, 255, 1);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'hFF);
    advanceTo(800);
    pushExp(8'h40, 64, 1);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'h40);
    advanceTo(1124);
    pushExp(8'hC0, 192, 1);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'hC0);
    advanceTo(1180);
    checkOutput("duty_held_mid_period", {24'd0, duty_q}, 8'h40);

    // Sigma-delta at 0x80 then 0x01
    advanceTo(1300);
    pushExp(8'h80, 128, 128);
    applyStimulus(1'b1, DAC_MODE_SD, 8'h80);
    advanceTo(1792);
    pushExp(8'h80, 1, 1);
    pushExp(8'h01, 1, 1);
    applyStimulus(1'b1, DAC_MODE_SD, 8'h01);

    // Mode switch back to PWM mid-period takes effect at the next wrap
    advanceTo(2098);
    pushExp(8'h01, 1, 0);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'h01);
    advanceTo(2304);
    checkOutput("acc_cleared_on_switch", {23'd0, dut.u_sd.acc_q}, 0);
    advanceTo(2314);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'h80);

    // Enable drop mid-period with the pin high
    advanceTo(2590);
    checkOutput("dac_high_before_drop", {31'd0, dac_out}, 1);
    applyStimulus(1'b0, DAC_MODE_PWM, 8'h80);
    @(posedge clk);
    #1;
    checkOutput("drop_dac_out", {31'd0, dac_out}, 0);
    checkOutput("drop_duty", {24'd0, duty_q}, 0);
    checkOutput("drop_period_start", {31'd0, period_start}, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_dac_out", {31'd0, dac_out}, 0);

    // Re-enable: period starts one cycle later
    pushExp(8'h80, 128, 1);
    applyStimulus(1'b1, DAC_MODE_PWM, 8'h80);
    @(posedge clk);
    #1;
    pos = 0;
    checkOutput("reenable_period_start", {31'd0, period_start}, 1);
    checkOutput("reenable_duty", {24'd0, duty_q}, 8'h80);

    // Asynchronous reset between edges
    advanceTo(296);
    checkOutput("dac_high_before_rst", {31'd0, dac_out}, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_dac_out", {31'd0, dac_out}, 0);
    checkOutput("async_rst_duty", {24'd0, duty_q}, 0);
    checkOutput("async_rst_period_start", {31'd0, period_start}, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_period_start", {31'd0, period_start}, 0);
    applyStimulus(1'b0, DAC_MODE_PWM, 8'h00);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_pwm_dac.md
Name: dds_pwm_dac

Overview:
- Output stage directly downstream of the DDS top level.
- Consumes the 8-bit DDS sample stream and turns it into a 1-bit pin drive that an external RC low-pass filter reconstructs into an analogue waveform.
- Two selectable modes:
  - PWM with a double-buffered duty register.
  - First-order sigma-delta modulator.
- Mode changes and duty updates take effect only on period boundaries, so the pin never carries a glitch.

Parameters:
- DATA_W, 8, sample width; PWM period = 2^DATA_W clk cycles.

Ports:
- clk  input  1  system clock, same domain as the DDS.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  run request; low forces idle.
- mode  input  1  0 = PWM, 1 = sigma-delta; sampled at period boundary only.
- sample_in  input  DATA_W  unsigned sample from the DDS output; valid every cycle.
- dac_out  output  1  registered 1-bit DAC drive.
- period_start  output  1  high for one cycle when cnt_q == 0 while enabled.
- duty_q  output  DATA_W  currently applied PWM duty (debug/readback).

Behaviour:
- Reset (async, rst=1):
  - cnt_q = 2^DATA_W-1, duty_q = 0, mode_q = 0, acc_q = 0.
  - dac_out = 0, period_start = 0.
  - All take effect immediately, mid-period included.
- enable=0 (synchronous idle): each edge loads the same values as reset. A deassert mid-period forces dac_out=0 at the next edge.
- Counter:
  - While enabled, cnt_q <= cnt_q+1, wrapping 2^DATA_W-1 -> 0.
  - First enabled edge after idle: cnt_q goes MAX -> 0, so the first period starts exactly one cycle after enable rises.
- Boundary edge (enable=1 and cnt_q == MAX):
  - duty_q <= sample_in, mode_q <= mode.
  - If mode_q changes, acc_q <= 0.
  - sample_in and mode at all other edges are ignored for duty/mode.
- PWM (mode_q=0):
  - dac_out <= (cnt_q < duty_q), unsigned compare.
  - Each period is high for exactly duty_q cycles.
  - dac_out lags cnt_q by one register stage, so the high pulse begins at the edge after cnt_q==0.
  - duty 0: never high. duty MAX: high 2^DATA_W-1 of 2^DATA_W cycles. Full-scale 100% is not reachable, by design.
- Sigma-delta (mode_q=1):
  - acc_q is DATA_W+1 bits. Each enabled edge: sum = {1'b0, acc_q[DATA_W-1:0]} + sample_in.
  - acc_q <= sum, dac_out <= sum[DATA_W] (the carry).
  - sample_in is used every cycle, not latched.
  - cnt_q keeps running so the boundary logic is identical in both modes.
  - Ones-density over any 2^DATA_W window after a boundary equals sample_in/2^DATA_W for a constant input.
- period_start: combinational decode of (enable && cnt_q == 0); one cycle per period in both modes.
- Latency: a sample presented on a boundary edge appears on dac_out from the 2nd cycle of the following period.
- Simultaneous events:
  - enable falling on a boundary edge: idle wins; duty is not loaded.
  - mode change with rst: rst wins.

Decomposition:
- Shared package/header dds_pkg:
  - DAC_MODE_PWM = 1'b0 and DAC_MODE_SD = 1'b1.
  - DDS_SAMPLE_W = 8.
- One natural sub-module: dds_sd_mod, holding the accumulator and carry output.
  - Ports: clk, rst, clear, enable, sample, bit_out.
- Counter, boundary latch and PWM compare stay in dds_pwm_dac.

Test Plan:
1. PWM duty: mode=0, sample_in=8'h40 held, enable rises -> period_start every 256 cycles; dac_out high for exactly 64 consecutive cycles per period, starting the cycle after period_start; duty_q=8'h40.
2. PWM extremes: sample 8'h00 -> dac_out 0 for a full period; 8'hFF -> 255 high, 1 low per period; a sample change mid-period (8'h40 -> 8'hC0 at cnt 100) leaves that period at 64 high, and the next period is 192 high.
3. Sigma-delta: mode=1, sample=8'h80 -> after the boundary, dac_out pattern is 0,1,0,1,...; ones count = 128 per 256 cycles. sample=8'h01 -> exactly 1 one per 256 cycles.
4. Mode switch: toggle mode at cnt_q=50 -> no change until cnt_q wraps; acc_q=0 at the boundary; the new mode output appears on the next cycle; no extra pulses on dac_out.
5. Enable/reset mid-operation:
   - enable drops at cnt 30 with dac_out=1 -> dac_out=0 next edge; duty_q=0.
   - Re-enable -> period_start one cycle later.
   - rst pulse asserted between edges -> dac_out, duty_q, period_start go to 0 immediately, without waiting for a clock edge.
